// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   usr_op_e          operation select encoding (hold / shift right / shift left / load)
//   USR_DEFAULT_WIDTH default register width
package usr_pkg;

  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_op_e;

  localparam int USR_DEFAULT_WIDTH = 4;

endpackage : usr_pkg

// File: rtl/usr_next_q.sv
// Combinational next-state mux for the universal shift register.
// Ports:
//   q_i           current register contents
//   op_i          operation for this cycle
//   p_din_i       parallel load data
//   s_left_din_i  serial bit entering at the LSB on a left shift
//   s_right_din_i serial bit entering at the MSB on a right shift
//   rotate_i      1: shifts recirculate the leaving bit instead of taking serial input
//   q_d_o         next register contents
module usr_next_q
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  usr_op_e          op_i,
  input  logic [WIDTH-1:0] p_din_i,
  input  logic             s_left_din_i,
  input  logic             s_right_din_i,
  input  logic             rotate_i,
  output logic [WIDTH-1:0] q_d_o
);

  logic msb_in;
  logic lsb_in;

  // In rotate mode the bit falling off one end re-enters at the other.
  assign msb_in = rotate_i ? q_i[0]       : s_right_din_i;
  assign lsb_in = rotate_i ? q_i[WIDTH-1] : s_left_din_i;

  always_comb begin
    q_d_o = q_i;
    case (op_i)
      USR_SHR:  q_d_o = {msb_in, q_i[WIDTH-1:1]};
      USR_SHL:  q_d_o = {q_i[WIDTH-2:0], lsb_in};
      USR_LOAD: q_d_o = p_din_i;
      // HOLD and any unknown select keep the current value.
      default:  q_d_o = q_i;
    endcase
  end

endmodule : usr_next_q

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: hold, shift right, shift left or parallel load
// chosen each cycle by select. Serial outputs are direct taps of the register.
// Optional build macro: USR_ROTATE_EN adds the rotate input (shifts recirculate).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low clear
//   select       operation (00 hold, 01 shift right, 10 shift left, 11 load)
//   p_din        parallel load data
//   s_left_din   serial input for shift-left (enters at LSB)
//   s_right_din  serial input for shift-right (enters at MSB)
//   rotate       (USR_ROTATE_EN only) 1: shifts rotate, serial inputs ignored
//   p_dout       register contents
//   s_left_dout  MSB, the bit a left shift discards
//   s_right_dout LSB, the bit a right shift discards
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
`ifdef USR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             rotate_en;

`ifdef USR_ROTATE_EN
  assign rotate_en = rotate;
`else
  assign rotate_en = 1'b0;
`endif

  usr_next_q #(
    .WIDTH(WIDTH)
  ) u_next_q (
    .q_i          (q_q),
    .op_i         (usr_op_e'(select)),
    .p_din_i      (p_din),
    .s_left_din_i (s_left_din),
    .s_right_din_i(s_right_din),
    .rotate_i     (rotate_en),
    .q_d_o        (q_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign p_dout       = q_q;
  assign s_left_dout  = q_q[WIDTH-1];
  assign s_right_dout = q_q[0];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int W = 4;
`ifdef USR_ROTATE_EN
  localparam bit ROT_AVAIL = 1'b1;
`else
  localparam bit ROT_AVAIL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   select;
  logic [W-1:0] p_din;
  logic         s_left_din;
  logic         s_right_din;
  logic         rotate;
  logic [W-1:0] p_dout;
  logic         s_left_dout;
  logic         s_right_dout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model state, as a plain integer
  int m_q = 0;
  int m_bin;
  bit m_rot;

  // pending directed expectation (checked one cycle later, 2ns before the edge)
  bit    pend_valid = 1'b0;
  int    pend_q     = 0;
  string pend_tag   = "";

  universal_shift_register #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .select      (select),
    .p_din       (p_din),
    .s_left_din  (s_left_din),
    .s_right_din (s_right_din),
`ifdef USR_ROTATE_EN
    .rotate      (rotate),
`endif
    .p_dout      (p_dout),
    .s_left_dout (s_left_dout),
    .s_right_dout(s_right_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: shifts as integer halving/doubling.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q = 0;
    end else begin
      m_rot = ROT_AVAIL && (rotate === 1'b1);
      case (select)
        2'd1: begin
          m_bin = m_rot ? (m_q % 2) : int'(s_right_din);
          m_q   = m_q / 2 + m_bin * (1 << (W - 1));
        end
        2'd2: begin
          m_bin = m_rot ? (m_q / (1 << (W - 1))) : int'(s_left_din);
          m_q   = (m_q * 2) % (1 << W) + m_bin;
        end
        2'd3: m_q = int'(p_din);
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #8;
    if (chk_en) begin
      check("mdl_p_dout", p_dout, m_q);
      check("mdl_s_left_dout", s_left_dout, m_q / (1 << (W - 1)));
      check("mdl_s_right_dout", s_right_dout, m_q % 2);
    end
  end

  task automatic check_pending();
    if (pend_valid) begin
      check(pend_tag, p_dout, pend_q);
      check({pend_tag, "_sl"}, s_left_dout, (pend_q >> (W - 1)) & 1);
      check({pend_tag, "_sr"}, s_right_dout, pend_q & 1);
    end
  endtask

  // Entered 3ns after an edge: drive, check the previous op 2ns before the
  // next edge, let that edge apply this op, return 3ns after it.
  task automatic op(input logic [1:0] sel, input logic [W-1:0] pd, input logic sl,
                    input logic sr, input logic rot, input bit chk, input int exp_q,
                    input string tag);
    select      = sel;
    p_din       = pd;
    s_left_din  = sl;
    s_right_din = sr;
    rotate      = rot;
    #5;
    check_pending();
    pend_valid = chk;
    pend_q     = exp_q;
    pend_tag   = tag;
    @(posedge clk);
    #3;
  endtask

  task automatic flush();
    select = 2'b00;
    #5;
    check_pending();
    pend_valid = 1'b0;
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b0; select = 2'b00; p_din = '0;
    s_left_din = 1'b0; s_right_din = 1'b0; rotate = 1'b0;
    @(posedge clk);
    #3;
    check("rst_p_dout", p_dout, 0);
    check("rst_s_left_dout", s_left_dout, 0);
    check("rst_s_right_dout", s_right_dout, 0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // asynchronous clear mid-cycle with q = F
    op(2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 15, "load_f");
    flush();
    #2 reset = 1'b0;
    #1;
    check("arst_p_dout", p_dout, 0);
    check("arst_s_left_dout", s_left_dout, 0);
    check("arst_s_right_dout", s_right_dout, 0);
    @(posedge clk);
    #3 reset = 1'b1;

    // load then hold with p_din toggling
    op(2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, "load_1011");
    op(2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, "hold1");
    op(2'b00, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, "hold2");
    op(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, "hold3");

    // shift right with 0 entering at MSB
    op(2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, "load_shr");
    op(2'b01, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, "shr1");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, "shr2");

    // shift left with 1 entering at LSB
    op(2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, "load_shl");
    op(2'b10, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111, "shl1");
    op(2'b10, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, "shl2");

    // serial in 1,0,0,1 then serial out LSB first
    op(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "load_zero");
    op(2'b10, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, "s2p1");
    op(2'b10, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, "s2p2");
    op(2'b10, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, "s2p3");
    op(2'b10, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, "s2p4");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, "p2s1");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, "p2s2");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, "p2s3");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, "p2s4");

`ifdef USR_ROTATE_EN
    op(2'b11, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, "rot_load");
    op(2'b10, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, "rot_shl");
    op(2'b01, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, "rot_shr");
`endif
    flush();

    // randomized traffic against the model, with occasional async clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1 check("rnd_arst_p_dout", p_dout, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        #3;
      end
      op(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, "rnd");
    end
    flush();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_universal_shift_register
